// File: rtl/demod_sample_fifo.sv
// demod_sample_fifo: first-word-fall-through buffer for lock-in demodulator
// results. Each completion tick stamps the sample with a free-running
// sequence number so that overflow drops appear as gaps to software.
module demod_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic signed [23:0] x1_i,
    input  logic signed [23:0] x2_i,
    input  logic               rd_i,
    output logic signed [31:0] x1_o,
    output logic signed [31:0] x2_o,
    output logic        [31:0] seq_o,
    output logic               empty_o,
    output logic               full_o,
    output logic      [LW-1:0] level_o,
    output logic        [15:0] drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);

    // Entry layout: {x1[23:0], x2[23:0], seq[31:0]}
    logic [79:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [31:0]   seq_cnt;
    logic [LW-1:0] level_nxt;
    logic [79:0]   new_entry;
    logic [79:0]   head_val;
    logic          head_load;
    logic          push_ok;
    logic          pop_ok;
    logic          drop;

    // Accept/drop decisions, next occupancy and the next head entry; a pop
    // that frees a slot in a full FIFO lets the same-cycle tick in, and the
    // freshly written sample is bypassed when it becomes the head at once.
    always_comb begin
        pop_ok     = rd_i && (level_o != '0);
        push_ok    = tick_i && ((level_o != LW'(DEPTH)) || pop_ok);
        drop       = tick_i && !push_ok;
        new_entry  = {x1_i, x2_i, seq_cnt};
        rd_ptr_nxt = rd_ptr + AW'(1);
        level_nxt  = level_o;
        head_load  = 1'b0;
        head_val   = mem[rd_ptr_nxt];
        case ({push_ok, pop_ok})
            2'b10:   level_nxt = level_o + LW'(1);
            2'b01:   level_nxt = level_o - LW'(1);
            default: level_nxt = level_o;
        endcase
        if (push_ok && (level_o == '0)) begin
            head_load = 1'b1;
            head_val  = new_entry;
        end else if (pop_ok && (level_nxt != '0)) begin
            head_load = 1'b1;
            if (push_ok && (level_o == LW'(1))) begin
                head_val = new_entry;
            end
        end
    end

    // Sample storage; deliberately not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy, flags, sequence stamp and saturating drop count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seq_cnt    <= '0;
            level_o    <= '0;
            empty_o    <= 1'b1;
            full_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (tick_i) begin
                seq_cnt <= seq_cnt + 32'd1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (drop && (drop_cnt_o != 16'hFFFF)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end
            level_o <= level_nxt;
            empty_o <= (level_nxt == '0);
            full_o  <= (level_nxt == LW'(DEPTH));
        end
    end

    // Registered head copy; holds its last value once the FIFO drains.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x1_o  <= '0;
            x2_o  <= '0;
            seq_o <= '0;
        end else if (head_load) begin
            x1_o  <= {{8{head_val[79]}}, head_val[79:56]};
            x2_o  <= {{8{head_val[55]}}, head_val[55:32]};
            seq_o <= head_val[31:0];
        end
    end

endmodule

// File: doc/demod_sample_fifo.md
# demod_sample_fifo

Buffers lock-in demodulator results for readout by the processor. Each demodulator completion tick captures one sample (x1, x2, and a 32-bit sequence number) into a first-word-fall-through FIFO. Software pops samples one at a time through a read strobe. Dropped samples on overflow are counted and show up as gaps in the sequence numbers. The block sits directly downstream of the QPD demodulator, in place of the direct register/counter tap.

## Interface
Parameters:
- DEPTH, 16, number of sample slots; power of two, ≥ 2.
- LW, $clog2(DEPTH)+1, width of level_o.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- tick_i  in  1  single-cycle pulse; demodulator result valid this cycle.
- x1_i  in  24 signed  demodulated x1.
- x2_i  in  24 signed  demodulated x2.
- rd_i  in  1  single-cycle pop strobe from the register interface.
- x1_o  out  32 signed  head sample x1, sign-extended from 24 bits.
- x2_o  out  32 signed  head sample x2, sign-extended from 24 bits.
- seq_o  out  32 unsigned  sequence number of the head sample.
- empty_o  out  1  FIFO holds no samples.
- full_o  out  1  FIFO holds DEPTH samples.
- level_o  out  LW  number of samples held, 0..DEPTH.
- drop_cnt_o  out  16 unsigned  samples lost to overflow; saturating.

## Operation
- Sequence counter (32-bit, internal):
  - Every tick_i stamps the sample with the current value, then increments it.
  - This applies to accepted and dropped ticks alike.
  - Wraps 0xFFFFFFFF → 0.
  - The first sample after reset has seq 0.
- Storage: circular buffer of DEPTH × 80 bits (x1, x2, seq). Write and read pointers are log2(DEPTH) bits and wrap naturally. An explicit level counter tracks occupancy.
- Push: tick_i with level < DEPTH stores the sample at the write pointer and advances it.
- Pop: rd_i with level > 0 advances the read pointer. rd_i while empty is ignored; no state changes.
- Overflow: tick_i while full with no accepted pop in the same cycle:
  - The new sample is discarded and the FIFO contents are unchanged.
  - drop_cnt_o increments, saturating at 0xFFFF.
  - The sequence counter still increments.
- Simultaneous tick_i and rd_i:
  - Level 0: the push is accepted and the pop is ignored; level becomes 1.
  - Level 1..DEPTH-1: both are accepted; level is unchanged.
  - Level DEPTH: both are accepted (the pop frees the slot); level stays DEPTH; no drop.
- Head outputs:
  - Registered copy of the entry at the read pointer.
  - Updated whenever the head changes: after a push into an empty FIFO, or after a pop that leaves the FIFO non-empty.
  - When the FIFO becomes empty, x1_o/x2_o/seq_o hold their last value; empty_o is the sole validity indicator.
- Flags: empty_o = (level == 0), full_o = (level == DEPTH); both registered, consistent with level_o every cycle.

## Timing
- Reset (reset_i high at a clock edge), values from the next cycle:
  - x1_o, x2_o, seq_o, level_o, drop_cnt_o = 0; empty_o = 1; full_o = 0.
  - Pointers and sequence counter = 0.
  - Memory contents are not cleared.
- Reset has priority over tick_i and rd_i in the same cycle. Asserting reset mid-operation discards all samples and zeroes drop_cnt_o.
- Push latency: tick_i in cycle N into an empty FIFO gives empty_o = 0, level_o = 1 and valid head outputs in cycle N+1.
- Pop latency: rd_i in cycle N gives the next head, level_o and flags in cycle N+1. The register interface may issue back-to-back rd_i on consecutive cycles.
- Throughput: one push and one pop per cycle, sustained.
- tick_i wider than one cycle counts as one tick per cycle high. Pulse shaping is the driver's responsibility.

## Test plan
- Reset, single push, pop:
  - Stimulus: reset; one tick with x1 = -5, x2 = 0x7FFFFF; one cycle later, rd_i.
  - Required: cycle after tick gives x1_o = 0xFFFFFFFB, x2_o = 0x007FFFFF, seq_o = 0, level_o = 1. Cycle after rd_i gives empty_o = 1, level_o = 0, outputs held.
- Fill and drain, DEPTH = 16:
  - Stimulus: 16 ticks with x1 = k; then 16 back-to-back rd_i.
  - Required: full_o = 1 after the 16th tick. Pops return seq 0..15 in order with x1_o = 0..15. empty_o = 1 after the last pop; drop_cnt_o = 0.
- Overflow:
  - Stimulus: fill to 16, then 3 more ticks; then drain.
  - Required: drop_cnt_o = 3; level_o stays 16. Drained seqs are 0..15. A following tick stores seq 19.
- Simultaneous events:
  - Stimulus 1: tick_i + rd_i at level 0. Required: level_o = 1, head = new sample.
  - Stimulus 2: tick_i + rd_i at level 16. Required: level_o = 16, drop_cnt_o unchanged, new tail seq is previous tail seq + 1.
- Pop on empty, reset mid-fill:
  - Stimulus: rd_i ×5 on empty.
  - Required: no state change, level_o = 0.
  - Stimulus: 7 ticks, then reset coincident with tick_i.
  - Required: level_o = 0, empty_o = 1. The next tick gets seq 0.
- Saturation and wrap:
  - Stimulus: preload the sequence counter to 0xFFFFFFFF (via force) with the FIFO full; push 70000 ticks; then drain one and push two.
  - Required: drop_cnt_o saturates at 0xFFFF. The two stamped seqs wrap correctly: seq 0xFFFFFFFF is followed by seq 0, modulo the consumed ticks.
